culsans_axi_id_remap: RTL and testbench

Parametrised AXI ID compressor between the crossbar master port and a narrow-ID slave such as the DRAM controller. It maps wide crossbar IDs (InIdWidth) onto a table of 2**OutIdWidth narrow IDs and restores the original ID on responses. Same-ID ordering is preserved by always pinning an active wide ID to one slot. Independent tables serve AW/B and AR/R. Only ID and handshake signals pass through this block; the wrapper carries channel payload alongside unchanged.

---
 rtl/culsans_axi_id_remap.sv | 234 +++++++++++++++++++++++
 tb/tb_culsans_axi_id_remap.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/culsans_axi_id_remap.sv
// culsans_axi_id_remap: AXI ID compressor between the crossbar master port and a
// narrow-ID slave. Wide IDs are pinned to one of 2**OutIdWidth slots while they
// have transactions outstanding, and the original ID is restored on responses.
// Optional build macro: CULSANS_ID_REMAP_ERR_EN (stray-response detection and sticky err_o).

module culsans_axi_id_remap_table #(
  parameter int unsigned InIdWidth    = 6,
  parameter int unsigned OutIdWidth   = 4,
  parameter int unsigned MaxTxnsPerId = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [InIdWidth-1:0]  req_id_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  output logic [OutIdWidth-1:0] req_id_o,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  input  logic [OutIdWidth-1:0] rsp_id_i,
  input  logic                  rsp_valid_i,
  input  logic                  rsp_last_i,
  output logic                  rsp_ready_o,
  output logic [InIdWidth-1:0]  rsp_id_o,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  busy_o,
  output logic                  err_o
);
  localparam int unsigned NumSlots = 2 ** OutIdWidth;
  localparam int unsigned CntWidth = $clog2(MaxTxnsPerId + 1);
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxTxnsPerId);

  logic [InIdWidth-1:0]  tag_q [NumSlots];
  logic [CntWidth-1:0]   cnt_q [NumSlots];

  logic                  match_found;
  logic                  free_found;
  logic [OutIdWidth-1:0] match_idx;
  logic [OutIdWidth-1:0] free_idx;
  logic [OutIdWidth-1:0] sel_idx;
  logic                  usable;
  logic                  rsp_slot_valid;
  logic                  inc;
  logic                  dec;
  logic [NumSlots-1:0]   inc_vec;
  logic [NumSlots-1:0]   dec_vec;

  // Find the slot already pinned to the request ID and the lowest-index free slot.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int i = int'(NumSlots) - 1; i >= 0; i--) begin
      if ((cnt_q[i] != '0) && (tag_q[i] == req_id_i)) begin
        match_found = 1'b1;
        match_idx   = OutIdWidth'(i);
      end
      if (cnt_q[i] == '0) begin
        free_found = 1'b1;
        free_idx   = OutIdWidth'(i);
      end
    end
  end

  // A pinned ID must stay on its slot, so a saturated match stalls instead of spilling.
  assign sel_idx = match_found ? match_idx : free_idx;
  assign usable  = match_found ? (cnt_q[match_idx] < MaxCnt) : free_found;

  assign req_valid_o = rst_ni & req_valid_i & usable;
  assign req_ready_o = rst_ni & req_ready_i & usable;
  assign req_id_o    = rst_ni ? sel_idx : '0;

  assign rsp_slot_valid = (cnt_q[rsp_id_i] != '0);
  assign rsp_id_o       = rst_ni ? tag_q[rsp_id_i] : '0;

`ifdef CULSANS_ID_REMAP_ERR_EN
  logic err_q;

  // Responses to an empty slot are swallowed here rather than forwarded.
  assign rsp_valid_o = rst_ni & rsp_valid_i & rsp_slot_valid;
  assign rsp_ready_o = rst_ni & (rsp_slot_valid ? rsp_ready_i : 1'b1);

  // Remember any stray response until the next reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (rsp_valid_i && !rsp_slot_valid) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign rsp_valid_o = rst_ni & rsp_valid_i;
  assign rsp_ready_o = rst_ni & rsp_ready_i;
  assign err_o       = 1'b0;
`endif

  // Empty slots are never decremented, which also keeps stray responses from underflowing.
  assign inc = req_valid_i & req_ready_i & usable;
  assign dec = rsp_valid_i & rsp_ready_i & rsp_last_i & rsp_slot_valid;

  // Expand the single increment and decrement events into per-slot strobes.
  always_comb begin
    inc_vec           = '0;
    dec_vec           = '0;
    inc_vec[sel_idx]  = inc;
    dec_vec[rsp_id_i] = dec;
  end

  // Slot bookkeeping: tag capture on allocation, counter up/down (both at once cancels).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumSlots); i++) begin
        tag_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NumSlots); i++) begin
        if (inc_vec[i]) begin
          tag_q[i] <= req_id_i;
        end
        if (inc_vec[i] && !dec_vec[i]) begin
          cnt_q[i] <= cnt_q[i] + CntWidth'(1);
        end else if (dec_vec[i] && !inc_vec[i]) begin
          cnt_q[i] <= cnt_q[i] - CntWidth'(1);
        end
      end
    end
  end

  // The table is busy while any slot holds outstanding transactions.
  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < int'(NumSlots); i++) begin
      busy_o = busy_o | (cnt_q[i] != '0);
    end
  end

endmodule

module culsans_axi_id_remap #(
  parameter int unsigned InIdWidth    = 6,
  parameter int unsigned OutIdWidth   = 4,
  parameter int unsigned MaxTxnsPerId = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [InIdWidth-1:0]  aw_id_i,
  input  logic                  aw_valid_i,
  output logic                  aw_ready_o,
  output logic [OutIdWidth-1:0] aw_id_o,
  output logic                  aw_valid_o,
  input  logic                  aw_ready_i,
  input  logic [OutIdWidth-1:0] b_id_i,
  input  logic                  b_valid_i,
  output logic                  b_ready_o,
  output logic [InIdWidth-1:0]  b_id_o,
  output logic                  b_valid_o,
  input  logic                  b_ready_i,
  input  logic [InIdWidth-1:0]  ar_id_i,
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  output logic [OutIdWidth-1:0] ar_id_o,
  output logic                  ar_valid_o,
  input  logic                  ar_ready_i,
  input  logic [OutIdWidth-1:0] r_id_i,
  input  logic                  r_valid_i,
  input  logic                  r_last_i,
  output logic                  r_ready_o,
  output logic [InIdWidth-1:0]  r_id_o,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic                  idle_o,
  output logic                  err_o
);
  logic write_busy;
  logic read_busy;
  logic write_err;
  logic read_err;

  culsans_axi_id_remap_table #(
    .InIdWidth   (InIdWidth),
    .OutIdWidth  (OutIdWidth),
    .MaxTxnsPerId(MaxTxnsPerId)
  ) i_write_table (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_id_i   (aw_id_i),
    .req_valid_i(aw_valid_i),
    .req_ready_o(aw_ready_o),
    .req_id_o   (aw_id_o),
    .req_valid_o(aw_valid_o),
    .req_ready_i(aw_ready_i),
    .rsp_id_i   (b_id_i),
    .rsp_valid_i(b_valid_i),
    .rsp_last_i (1'b1),
    .rsp_ready_o(b_ready_o),
    .rsp_id_o   (b_id_o),
    .rsp_valid_o(b_valid_o),
    .rsp_ready_i(b_ready_i),
    .busy_o     (write_busy),
    .err_o      (write_err)
  );

  culsans_axi_id_remap_table #(
    .InIdWidth   (InIdWidth),
    .OutIdWidth  (OutIdWidth),
    .MaxTxnsPerId(MaxTxnsPerId)
  ) i_read_table (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_id_i   (ar_id_i),
    .req_valid_i(ar_valid_i),
    .req_ready_o(ar_ready_o),
    .req_id_o   (ar_id_o),
    .req_valid_o(ar_valid_o),
    .req_ready_i(ar_ready_i),
    .rsp_id_i   (r_id_i),
    .rsp_valid_i(r_valid_i),
    .rsp_last_i (r_last_i),
    .rsp_ready_o(r_ready_o),
    .rsp_id_o   (r_id_o),
    .rsp_valid_o(r_valid_o),
    .rsp_ready_i(r_ready_i),
    .busy_o     (read_busy),
    .err_o      (read_err)
  );

  assign idle_o = ~rst_ni | ~(write_busy | read_busy);
  assign err_o  = rst_ni & (write_err | read_err);

endmodule

// File: tb/tb_culsans_axi_id_remap.sv
// tb_culsans_axi_id_remap: directed self-checking bench for culsans_axi_id_remap.
// Expectations follow CULSANS_ID_REMAP_ERR_EN when it is defined for the build.

module tb_culsans_axi_id_remap;

  logic       clk_i;
  logic       rst_ni;
  logic [5:0] aw_id_i;
  logic       aw_valid_i;
  logic       aw_ready_o;
  logic [3:0] aw_id_o;
  logic       aw_valid_o;
  logic       aw_ready_i;
  logic [3:0] b_id_i;
  logic       b_valid_i;
  logic       b_ready_o;
  logic [5:0] b_id_o;
  logic       b_valid_o;
  logic       b_ready_i;
  logic [5:0] ar_id_i;
  logic       ar_valid_i;
  logic       ar_ready_o;
  logic [3:0] ar_id_o;
  logic       ar_valid_o;
  logic       ar_ready_i;
  logic [3:0] r_id_i;
  logic       r_valid_i;
  logic       r_last_i;
  logic       r_ready_o;
  logic [5:0] r_id_o;
  logic       r_valid_o;
  logic       r_ready_i;
  logic       idle_o;
  logic       err_o;

  int compareCount  = 0;
  int mismatchCount = 0;

  culsans_axi_id_remap #(
    .InIdWidth   (6),
    .OutIdWidth  (4),
    .MaxTxnsPerId(8)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .aw_id_i   (aw_id_i),
    .aw_valid_i(aw_valid_i),
    .aw_ready_o(aw_ready_o),
    .aw_id_o   (aw_id_o),
    .aw_valid_o(aw_valid_o),
    .aw_ready_i(aw_ready_i),
    .b_id_i    (b_id_i),
    .b_valid_i (b_valid_i),
    .b_ready_o (b_ready_o),
    .b_id_o    (b_id_o),
    .b_valid_o (b_valid_o),
    .b_ready_i (b_ready_i),
    .ar_id_i   (ar_id_i),
    .ar_valid_i(ar_valid_i),
    .ar_ready_o(ar_ready_o),
    .ar_id_o   (ar_id_o),
    .ar_valid_o(ar_valid_o),
    .ar_ready_i(ar_ready_i),
    .r_id_i    (r_id_i),
    .r_valid_i (r_valid_i),
    .r_last_i  (r_last_i),
    .r_ready_o (r_ready_o),
    .r_id_o    (r_id_o),
    .r_valid_o (r_valid_o),
    .r_ready_i (r_ready_i),
    .idle_o    (idle_o),
    .err_o     (err_o)
  );

  // Free-running 100 MHz clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  // Commit the current inputs through one rising edge, then step off the edge.
  task automatic applyStimulus();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clearInputs();
    aw_id_i = '0; aw_valid_i = 1'b0; aw_ready_i = 1'b0;
    b_id_i  = '0; b_valid_i  = 1'b0; b_ready_i  = 1'b0;
    ar_id_i = '0; ar_valid_i = 1'b0; ar_ready_i = 1'b0;
    r_id_i  = '0; r_valid_i  = 1'b0; r_last_i   = 1'b0; r_ready_i = 1'b0;
  endtask

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got 0x0, want 0x1 (run did not complete)");
    $fatal(1, "[TB] timeout");
  end

  // Directed scenario sequence.
  initial begin
    clearInputs();
    rst_ni = 1'b0;

    // Reset: outputs must stay quiet even with handshakes driven.
    aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_id_i = 6'h15;
    ar_valid_i = 1'b1; ar_ready_i = 1'b1;
    b_valid_i  = 1'b1; b_ready_i  = 1'b1; b_id_i = 4'h3;
    r_valid_i  = 1'b1; r_ready_i  = 1'b1;
    applyStimulus();
    #1;
    checkOutput("rst aw_valid_o", 32'(aw_valid_o), 0);
    checkOutput("rst aw_ready_o", 32'(aw_ready_o), 0);
    checkOutput("rst aw_id_o",    32'(aw_id_o),    0);
    checkOutput("rst ar_ready_o", 32'(ar_ready_o), 0);
    checkOutput("rst b_valid_o",  32'(b_valid_o),  0);
    checkOutput("rst b_ready_o",  32'(b_ready_o),  0);
    checkOutput("rst b_id_o",     32'(b_id_o),     0);
    checkOutput("rst r_valid_o",  32'(r_valid_o),  0);
    checkOutput("rst idle_o",     32'(idle_o),     1);
    checkOutput("rst err_o",      32'(err_o),      0);
    applyStimulus();
    rst_ni = 1'b1;
    clearInputs();

    // Single AR 0x2A: zero-latency grant on slot 0, then restored on R.
    ar_id_i = 6'h2A; ar_valid_i = 1'b1; ar_ready_i = 1'b1;
    #1;
    checkOutput("t1 ar_valid_o", 32'(ar_valid_o), 1);
    checkOutput("t1 ar_ready_o", 32'(ar_ready_o), 1);
    checkOutput("t1 ar_id_o",    32'(ar_id_o),    0);
    checkOutput("t1 idle before", 32'(idle_o),    1);
    applyStimulus();
    ar_valid_i = 1'b0; ar_ready_i = 1'b0;
    #1;
    checkOutput("t1 idle busy", 32'(idle_o), 0);
    r_id_i = 4'd0; r_valid_i = 1'b1; r_last_i = 1'b1; r_ready_i = 1'b1;
    #1;
    checkOutput("t1 r_id_o",    32'(r_id_o),    'h2A);
    checkOutput("t1 r_valid_o", 32'(r_valid_o), 1);
    checkOutput("t1 r_ready_o", 32'(r_ready_o), 1);
    applyStimulus();
    r_valid_i = 1'b0; r_last_i = 1'b0;
    #1;
    checkOutput("t1 idle after", 32'(idle_o), 1);

    // Eight AW with ID 0x05 saturate slot 0; the ninth stalls until a B returns.
    aw_id_i = 6'h05; aw_valid_i = 1'b1; aw_ready_i = 1'b1; b_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checkOutput("t2 aw_id_o",    32'(aw_id_o),    0);
      checkOutput("t2 aw_ready_o", 32'(aw_ready_o), 1);
      applyStimulus();
    end
    #1;
    checkOutput("t2 stall ready", 32'(aw_ready_o), 0);
    checkOutput("t2 stall valid", 32'(aw_valid_o), 0);
    b_id_i = 4'd0; b_valid_i = 1'b1;
    #1;
    checkOutput("t2 b_id_o",       32'(b_id_o),     'h05);
    checkOutput("t2 b_valid_o",    32'(b_valid_o),  1);
    checkOutput("t2 stall during", 32'(aw_ready_o), 0);
    applyStimulus();
    b_valid_i = 1'b0;
    #1;
    checkOutput("t2 ninth ready", 32'(aw_ready_o), 1);
    checkOutput("t2 ninth valid", 32'(aw_valid_o), 1);
    checkOutput("t2 ninth id",    32'(aw_id_o),    0);
    applyStimulus();
    aw_valid_i = 1'b0;
    #1;
    checkOutput("t2 resaturated", 32'(aw_ready_o), 0);
    b_id_i = 4'd0; b_valid_i = 1'b1;
    repeat (8) applyStimulus();
    b_valid_i = 1'b0;
    #1;
    checkOutput("t2 drained idle", 32'(idle_o), 1);

    // Same-cycle AW and B on slot 2 keep the slot alive with its tag.
    for (int i = 0; i < 3; i++) begin
      aw_id_i = 6'(32'h20 + i); aw_valid_i = 1'b1;
      #1;
      checkOutput("t5 fill id", 32'(aw_id_o), 32'(i));
      applyStimulus();
    end
    aw_id_i = 6'h22; aw_valid_i = 1'b1;
    b_id_i = 4'd2; b_valid_i = 1'b1;
    #1;
    checkOutput("t5 aw_id_o",  32'(aw_id_o),  2);
    checkOutput("t5 b_id_o",   32'(b_id_o),   'h22);
    checkOutput("t5 b_valid_o", 32'(b_valid_o), 1);
    applyStimulus();
    aw_valid_i = 1'b0; b_valid_i = 1'b0;
    #1;
    checkOutput("t5 still pinned", 32'(aw_id_o), 2);
    aw_id_i = 6'h33;
    #1;
    checkOutput("t5 new id skips 2", 32'(aw_id_o), 3);
    b_id_i = 4'd2; b_valid_i = 1'b1;
    #1;
    checkOutput("t5 tag kept", 32'(b_id_o), 'h22);
    applyStimulus();
    b_valid_i = 1'b0;
    #1;
    checkOutput("t5 slot 2 freed", 32'(aw_id_o), 2);
    b_id_i = 4'd0; b_valid_i = 1'b1;
    applyStimulus();
    b_id_i = 4'd1;
    applyStimulus();
    b_valid_i = 1'b0; aw_ready_i = 1'b0;
    #1;
    checkOutput("t5 drained idle", 32'(idle_o), 1);

    // Sixteen distinct AR IDs fill the read table; 0x10 waits for slot 3.
    ar_valid_i = 1'b1; ar_ready_i = 1'b1; r_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ar_id_i = 6'(i);
      #1;
      checkOutput("t3 fill id",    32'(ar_id_o),    32'(i));
      checkOutput("t3 fill valid", 32'(ar_valid_o), 1);
      applyStimulus();
    end
    ar_id_i = 6'h10;
    #1;
    checkOutput("t3 full ready", 32'(ar_ready_o), 0);
    checkOutput("t3 full valid", 32'(ar_valid_o), 0);
    r_id_i = 4'd3; r_valid_i = 1'b1; r_last_i = 1'b1;
    #1;
    checkOutput("t3 r_id_o",        32'(r_id_o),     3);
    checkOutput("t3 drain cycle",   32'(ar_ready_o), 0);
    applyStimulus();
    r_valid_i = 1'b0; r_last_i = 1'b0;
    #1;
    checkOutput("t3 grant ready", 32'(ar_ready_o), 1);
    checkOutput("t3 grant id",    32'(ar_id_o),    3);
    applyStimulus();
    ar_id_i = 6'h3F;

    // Four-beat burst on slot 1 frees it only after the last-beat handshake.
    r_id_i = 4'd1; r_valid_i = 1'b1; r_last_i = 1'b0; r_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("t4 beat r_id_o",  32'(r_id_o),     1);
      checkOutput("t4 beat held",    32'(ar_ready_o), 0);
      applyStimulus();
    end
    r_ready_i = 1'b0; r_last_i = 1'b1;
    #1;
    checkOutput("t4 wait r_ready_o", 32'(r_ready_o), 0);
    checkOutput("t4 wait r_valid_o", 32'(r_valid_o), 1);
    applyStimulus();
    r_ready_i = 1'b1;
    #1;
    checkOutput("t4 last cycle held", 32'(ar_ready_o), 0);
    applyStimulus();
    r_valid_i = 1'b0; r_last_i = 1'b0;
    #1;
    checkOutput("t4 freed ready", 32'(ar_ready_o), 1);
    checkOutput("t4 freed id",    32'(ar_id_o),    1);
    applyStimulus();
    ar_valid_i = 1'b0;
    r_valid_i = 1'b1; r_last_i = 1'b1; r_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      r_id_i = 4'(i);
      #1;
      if (i == 3) checkOutput("t4 slot3 tag", 32'(r_id_o), 'h10);
      if (i == 1) checkOutput("t4 slot1 tag", 32'(r_id_o), 'h3F);
      applyStimulus();
    end
    r_valid_i = 1'b0; r_last_i = 1'b0;
    #1;
    checkOutput("t4 drained idle", 32'(idle_o), 1);

    // B on empty slot 7.
    b_id_i = 4'd7; b_valid_i = 1'b1; b_ready_i = 1'b1;
    #1;
`ifdef CULSANS_ID_REMAP_ERR_EN
    checkOutput("t6 stray b_ready_o", 32'(b_ready_o), 1);
    checkOutput("t6 stray b_valid_o", 32'(b_valid_o), 0);
    checkOutput("t6 err before edge", 32'(err_o),     0);
`else
    checkOutput("t6 stray b_ready_o", 32'(b_ready_o), 1);
    checkOutput("t6 stray b_valid_o", 32'(b_valid_o), 1);
    checkOutput("t6 stray b_id_o",    32'(b_id_o),    0);
`endif
    applyStimulus();
    b_valid_i = 1'b0;
    #1;
`ifdef CULSANS_ID_REMAP_ERR_EN
    checkOutput("t6 err set", 32'(err_o), 1);
`else
    checkOutput("t6 err tied", 32'(err_o), 0);
`endif
    checkOutput("t6 no underflow idle", 32'(idle_o), 1);
    applyStimulus();
    #1;
`ifdef CULSANS_ID_REMAP_ERR_EN
    checkOutput("t6 err held", 32'(err_o), 1);
`else
    checkOutput("t6 err still 0", 32'(err_o), 0);
`endif
    rst_ni = 1'b0;
    applyStimulus();
    checkOutput("t6 err after reset", 32'(err_o),  0);
    checkOutput("t6 idle in reset",   32'(idle_o), 1);
    rst_ni = 1'b1;
    applyStimulus();
    checkOutput("t6 err post reset", 32'(err_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
